// File: rtl/hugodg_clkdiv_pkg.sv
// Shared constants and the ratio clamp used by the programmable clock divider.
package hugodg_clkdiv_pkg;

    localparam int CNT_W   = 8;
    localparam int MIN_DIV = 2;

    // Ratios below MIN_DIV cannot form a high and a low phase, so clamp them up.
    function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] x);
        return (x < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : x;
    endfunction

endpackage

// File: rtl/div_counter.sv
// Programmable divide-by-N counter with a registered, near-50% divided clock output.
module div_counter
    import hugodg_clkdiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] ratio,
    output logic [CNT_W-1:0] cnt,
    output logic             div_q
);

    logic [CNT_W-1:0] n_q;
    logic             wrap;

    assign wrap = (cnt == n_q - CNT_W'(1));

    // A new ratio is taken only at the wrap, so a running period always completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            n_q   <= eff(ratio);
            div_q <= 1'b0;
        end else if (en) begin
            cnt   <= wrap ? '0 : cnt + CNT_W'(1);
            n_q   <= wrap ? eff(ratio) : n_q;
            div_q <= (cnt < (n_q >> 1));
        end
    end

endmodule

// File: rtl/hugodg_clock_divider.sv
// TinyTapeout tile: programmable clock divider on uo_out[0], fixed power-of-two taps on uo_out[7:1].
module hugodg_clock_divider
    import hugodg_clkdiv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [CNT_W-1:0] pc;
    logic [CNT_W-1:0] cnt;
    logic             div_q;
    logic             unused_bits;

    div_counter u_div_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (ena),
        .ratio (ui_in),
        .cnt   (cnt),
        .div_q (div_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (ena) begin
            pc <= pc + CNT_W'(1);
        end
    end

    assign uo_out  = {pc[6:0], div_q};
    assign uio_out = cnt;
    assign uio_oe  = 8'hFF;

    // uio pins are output-only and the top prescaler bit has no tap.
    assign unused_bits = ^{uio_in, pc[7]};

endmodule

// File: tb/tb_hugodg_clock_divider.sv
// Self-checking bench for hugodg_clock_divider: waveform-queue model plus directed literal pins.
module tb_hugodg_clock_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hugodg_clock_divider dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // ---------------- reference model ----------------
  // exp_q holds the remaining levels of the current divided-clock period:
  // floor(N/2) ones followed by ceil(N/2) zeros.
  logic [0:0] exp_q[$];
  int         m_n;
  int         m_cnt;
  logic       m_div;
  int         m_edges;

  function automatic int tb_eff(input int x);
    return (x < 2) ? 2 : x;
  endfunction

  task automatic load_period(input int n);
    m_n = n;
    for (int i = 0; i < n; i++) exp_q.push_back((i < n / 2) ? 1'b1 : 1'b0);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      load_period(tb_eff(int'(ui_in)));
      m_cnt   = 0;
      m_div   = 1'b0;
      m_edges = 0;
    end else if (ena) begin
      m_div   = exp_q.pop_front();
      m_edges = m_edges + 1;
      if (exp_q.size() == 0) begin
        m_cnt = 0;
        load_period(tb_eff(int'(ui_in)));
      end else begin
        m_cnt = m_n - exp_q.size();
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_uo_out", uo_out, {(m_edges % 128) == 0 ? 7'd0 : 7'(m_edges % 128), m_div});
      check("model_uio_out", uio_out, 32'(m_cnt));
      check("model_uio_oe", uio_oe, 8'hFF);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    uio_in = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] ratio, input int cycles);
    rst   = 1'b1;
    ena   = 1'b1;
    ui_in = ratio;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  task automatic expect_div(input string name, input logic [15:0] pat, input int len);
    for (int i = 0; i < len; i++) begin
      step();
      check(name, uo_out[0], pat[len-1-i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'd4;
    uio_in = 8'h00;
    @(negedge clk);
    step();
    chk_en = 1'b1;
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'hFF);

    // N=4: div 1,1,0,0 and count 1,2,3,0 after release
    rst = 1'b0;
    ena = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("n4_div", uo_out[0], ((i % 4) < 2) ? 1'b1 : 1'b0);
      check("n4_cnt", uio_out, 8'((i + 1) % 4));
    end
    check("prescaler_after_8", uo_out, 8'h10);

    // N=5: high 2, low 3
    do_reset(8'd5, 2);
    expect_div("n5_div", 16'b11000_11000, 10);

    // ratios below 2 clamp to 2
    do_reset(8'd0, 1);
    expect_div("n0_div", 16'b101010, 6);
    do_reset(8'd1, 1);
    expect_div("n1_div", 16'b101010, 6);

    // N=6, switch to 3 at cnt=2: period completes, then 1 high / 2 low
    do_reset(8'd6, 1);
    step();
    step();
    check("n6_cnt_before_change", uio_out, 8'd2);
    ui_in = 8'd3;
    expect_div("ratio_change_div", 16'b10001001, 8);

    // freeze for 10 cycles, then resume
    ena = 1'b0;
    repeat (10) step();
    ena = 1'b1;
    repeat (10) step();

    // longest ratio: cnt runs 0..254
    do_reset(8'd255, 1);
    repeat (600) step();
    check("n255_cnt_at_600", uio_out, 8'(600 % 255));

    // prescaler taps over a full /128 period
    do_reset(8'd4, 1);
    repeat (128) step();
    check("prescaler_wrap_128", uo_out[7:1], 7'd0);
    repeat (64) step();
    check("prescaler_tap7_half", uo_out[7], 1'b1);

    // randomized ratio, enable and reset activity
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0) ui_in = 8'($urandom);
        else                           ui_in = 8'($urandom_range(0, 12));
      end
      step();
    end

    // reset mid-run
    rst = 1'b0;
    ena = 1'b1;
    ui_in = 8'd7;
    repeat (37) step();
    rst = 1'b1;
    step();
    check("midrun_reset_uo_out", uo_out, 8'h00);
    check("midrun_reset_uio_out", uio_out, 8'h00);
    check("midrun_reset_uio_oe", uio_oe, 8'hFF);
    rst = 1'b0;
    repeat (20) step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
